// File: rtl/game_pkg.sv
// Shared types and constants for the tug-of-war match sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ROUND_CLR  = 3'd1,
    PLAY       = 3'd2,
    WIN_HOLD   = 3'd3,
    MATCH_OVER = 3'd4
  } state_t;

  // Match winner encoding
  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_RIGHT = 2'b01;
  localparam logic [1:0] WINNER_LEFT  = 2'b10;

  // Active-low 7-segment digit images, bit 6 = segment g
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;

endpackage

// File: rtl/match_controller_if.sv
// Control/status bundle between the match sequencer and the playfield/displays.
interface match_controller_if;
  logic       start;
  logic       l_win;
  logic       r_win;
  logic       play_en;
  logic       field_clr;
  logic [2:0] l_score;
  logic [2:0] r_score;
  logic [6:0] l_hex;
  logic [6:0] r_hex;
  logic       match_over;
  logic [1:0] winner;

  // Controller side
  modport slave (
    input  start, l_win, r_win,
    output play_en, field_clr, l_score, r_score, l_hex, r_hex, match_over, winner
  );

  // Stimulus / consumer side
  modport master (
    output start, l_win, r_win,
    input  play_en, field_clr, l_score, r_score, l_hex, r_hex, match_over, winner
  );
endinterface

// File: rtl/seg7_digit.sv
// Combinational 3-bit value to active-low 7-segment image.
module seg7_digit
  import game_pkg::*;
(
  input  logic [2:0] i_digit,
  output logic [6:0] o_seg
);

  // Digit lookup
  always_comb begin
    o_seg = SEG_0;
    case (i_digit)
      3'd0: o_seg = SEG_0;
      3'd1: o_seg = SEG_1;
      3'd2: o_seg = SEG_2;
      3'd3: o_seg = SEG_3;
      3'd4: o_seg = SEG_4;
      3'd5: o_seg = SEG_5;
      3'd6: o_seg = SEG_6;
      3'd7: o_seg = SEG_7;
      default: o_seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/match_controller.sv
// Best-of-N match sequencer: enables play, counts round wins, holds each
// result, clears the playfield between rounds and stops at the target score.
// Every output is a register loaded from the next-state decode, so outputs
// change exactly on the edge that changes the state.
module match_controller
  import game_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int WIN_SCORE   = 7
) (
  input  logic              clk,
  input  logic              reset,
  match_controller_if.slave bus
);

  localparam int            CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    WIN_MAX   = 3'(WIN_SCORE);

  state_t        r_state,     w_state_nxt;
  logic [CW-1:0] r_hold_cnt,  w_hold_nxt;
  logic [2:0]    r_l_score,   w_l_score_nxt;
  logic [2:0]    r_r_score,   w_r_score_nxt;
  logic [1:0]    r_winner,    w_winner_nxt;
  logic [6:0]    r_l_hex,     r_r_hex;
  logic [6:0]    w_l_seg,     w_r_seg;
  logic          r_play_en,   r_field_clr, r_match_over;

  // Digits decode the next score so the hex register tracks the score register
  seg7_digit u_l_seg (.i_digit(w_l_score_nxt), .o_seg(w_l_seg));
  seg7_digit u_r_seg (.i_digit(w_r_score_nxt), .o_seg(w_r_seg));

  // Next-state, hold counter, score and winner decode
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_l_score_nxt = r_l_score;
    w_r_score_nxt = r_r_score;
    w_winner_nxt  = r_winner;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_l_score_nxt = 3'd0;
          w_r_score_nxt = 3'd0;
          w_winner_nxt  = WINNER_NONE;
          w_state_nxt   = ROUND_CLR;
        end
      end
      ROUND_CLR: w_state_nxt = PLAY;
      PLAY: begin
        case ({bus.l_win, bus.r_win})
          2'b10: begin
            if (r_l_score < WIN_MAX) w_l_score_nxt = r_l_score + 3'd1;
            w_hold_nxt  = HOLD_LOAD;
            w_state_nxt = WIN_HOLD;
          end
          2'b01: begin
            if (r_r_score < WIN_MAX) w_r_score_nxt = r_r_score + 3'd1;
            w_hold_nxt  = HOLD_LOAD;
            w_state_nxt = WIN_HOLD;
          end
          // Tie: round is spent, nobody scores
          2'b11: begin
            w_hold_nxt  = HOLD_LOAD;
            w_state_nxt = WIN_HOLD;
          end
          default: w_state_nxt = PLAY;
        endcase
      end
      WIN_HOLD: begin
        if (r_hold_cnt == '0) begin
          if (r_l_score == WIN_MAX) begin
            w_winner_nxt = WINNER_LEFT;
            w_state_nxt  = MATCH_OVER;
          end else if (r_r_score == WIN_MAX) begin
            w_winner_nxt = WINNER_RIGHT;
            w_state_nxt  = MATCH_OVER;
          end else begin
            w_state_nxt  = ROUND_CLR;
          end
        end else begin
          w_hold_nxt = r_hold_cnt - 1'b1;
        end
      end
      MATCH_OVER: begin
        if (bus.start) begin
          w_l_score_nxt = 3'd0;
          w_r_score_nxt = 3'd0;
          w_winner_nxt  = WINNER_NONE;
          w_state_nxt   = ROUND_CLR;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      r_l_score    <= 3'd0;
      r_r_score    <= 3'd0;
      r_winner     <= WINNER_NONE;
      r_l_hex      <= SEG_0;
      r_r_hex      <= SEG_0;
      r_play_en    <= 1'b0;
      r_field_clr  <= 1'b0;
      r_match_over <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_l_score    <= w_l_score_nxt;
      r_r_score    <= w_r_score_nxt;
      r_winner     <= w_winner_nxt;
      r_l_hex      <= w_l_seg;
      r_r_hex      <= w_r_seg;
      r_play_en    <= (w_state_nxt == PLAY);
      r_field_clr  <= (w_state_nxt == ROUND_CLR);
      r_match_over <= (w_state_nxt == MATCH_OVER);
    end
  end

  assign bus.play_en    = r_play_en;
  assign bus.field_clr  = r_field_clr;
  assign bus.l_score    = r_l_score;
  assign bus.r_score    = r_r_score;
  assign bus.l_hex      = r_l_hex;
  assign bus.r_hex      = r_r_hex;
  assign bus.match_over = r_match_over;
  assign bus.winner     = r_winner;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with HOLD_CYCLES=4, WIN_SCORE=3.
module tb_match_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [6:0] exp_seg [0:7];

  match_controller_if bus();

  match_controller #(.HOLD_CYCLES(4), .WIN_SCORE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.play_en !== 1'b0) begin n_fail++; $display("FAIL reset_play_en got %b want 0", bus.play_en); end
    n_checks++; if (bus.field_clr !== 1'b0) begin n_fail++; $display("FAIL reset_field_clr got %b want 0", bus.field_clr); end
    n_checks++; if (bus.match_over !== 1'b0) begin n_fail++; $display("FAIL reset_match_over got %b want 0", bus.match_over); end
    n_checks++; if (bus.l_score !== 3'd0 || bus.r_score !== 3'd0) begin n_fail++; $display("FAIL reset_scores got %0d/%0d want 0/0", bus.l_score, bus.r_score); end
    n_checks++; if (bus.l_hex !== 7'b1000000 || bus.r_hex !== 7'b1000000) begin n_fail++; $display("FAIL reset_hex got %b/%b want 1000000", bus.l_hex, bus.r_hex); end
    n_checks++; if (bus.winner !== 2'b00) begin n_fail++; $display("FAIL reset_winner got %b want 00", bus.winner); end
  endtask

  task automatic test_idle_ignore();
    bus.l_win = 1'b1; bus.r_win = 1'b1;
    repeat (3) begin
      tick();
      n_checks++; if (bus.l_score !== 3'd0 || bus.r_score !== 3'd0 || bus.play_en !== 1'b0 || bus.field_clr !== 1'b0) begin
        n_fail++; $display("FAIL idle_ignore got l=%0d r=%0d pe=%b fc=%b want 0 0 0 0", bus.l_score, bus.r_score, bus.play_en, bus.field_clr);
      end
    end
    bus.l_win = 1'b0; bus.r_win = 1'b0;
  endtask

  task automatic test_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.field_clr !== 1'b1 || bus.play_en !== 1'b0) begin n_fail++; $display("FAIL start_clr got fc=%b pe=%b want 1 0", bus.field_clr, bus.play_en); end
    tick();
    n_checks++; if (bus.field_clr !== 1'b0 || bus.play_en !== 1'b1) begin n_fail++; $display("FAIL start_play got fc=%b pe=%b want 0 1", bus.field_clr, bus.play_en); end
    n_checks++; if (bus.l_hex !== 7'b1000000 || bus.r_hex !== 7'b1000000) begin n_fail++; $display("FAIL start_hex got %b/%b want 1000000", bus.l_hex, bus.r_hex); end
  endtask

  task automatic test_left_win();
    bus.l_win = 1'b1;
    tick();
    bus.l_win = 1'b0;
    n_checks++; if (bus.l_score !== 3'd1 || bus.l_hex !== 7'b1111001 || bus.play_en !== 1'b0) begin
      n_fail++; $display("FAIL left_win got l=%0d hex=%b pe=%b want 1 1111001 0", bus.l_score, bus.l_hex, bus.play_en);
    end
    repeat (3) begin
      tick();
      n_checks++; if (bus.play_en !== 1'b0 || bus.field_clr !== 1'b0) begin n_fail++; $display("FAIL left_hold got pe=%b fc=%b want 0 0", bus.play_en, bus.field_clr); end
    end
    tick();
    n_checks++; if (bus.field_clr !== 1'b1 || bus.play_en !== 1'b0) begin n_fail++; $display("FAIL left_clr got fc=%b pe=%b want 1 0", bus.field_clr, bus.play_en); end
    tick();
    n_checks++; if (bus.field_clr !== 1'b0 || bus.play_en !== 1'b1) begin n_fail++; $display("FAIL left_replay got fc=%b pe=%b want 0 1", bus.field_clr, bus.play_en); end
  endtask

  task automatic test_tie();
    bus.l_win = 1'b1; bus.r_win = 1'b1;
    tick();
    bus.l_win = 1'b0; bus.r_win = 1'b0;
    n_checks++; if (bus.l_score !== 3'd1 || bus.r_score !== 3'd0 || bus.play_en !== 1'b0) begin
      n_fail++; $display("FAIL tie_scores got l=%0d r=%0d pe=%b want 1 0 0", bus.l_score, bus.r_score, bus.play_en);
    end
    repeat (3) tick();
    n_checks++; if (bus.field_clr !== 1'b0) begin n_fail++; $display("FAIL tie_hold got fc=%b want 0", bus.field_clr); end
    tick();
    n_checks++; if (bus.field_clr !== 1'b1) begin n_fail++; $display("FAIL tie_clr got fc=%b want 1", bus.field_clr); end
    tick();
    n_checks++; if (bus.play_en !== 1'b1 || bus.l_score !== 3'd1 || bus.r_score !== 3'd0) begin
      n_fail++; $display("FAIL tie_replay got pe=%b l=%0d r=%0d want 1 1 0", bus.play_en, bus.l_score, bus.r_score);
    end
  endtask

  task automatic test_right_match();
    for (int i = 1; i <= 3; i++) begin
      bus.r_win = 1'b1;
      tick();
      bus.r_win = 1'b0;
      n_checks++; if (bus.r_score !== 3'(i) || bus.r_hex !== exp_seg[i]) begin
        n_fail++; $display("FAIL right_win%0d got r=%0d hex=%b want %0d %b", i, bus.r_score, bus.r_hex, i, exp_seg[i]);
      end
      // Left wins during the hold must be ignored
      bus.l_win = 1'b1;
      repeat (3) tick();
      bus.l_win = 1'b0;
      n_checks++; if (bus.l_score !== 3'd1) begin n_fail++; $display("FAIL hold_ignore%0d got l=%0d want 1", i, bus.l_score); end
      tick();
      if (i < 3) begin
        n_checks++; if (bus.field_clr !== 1'b1 || bus.match_over !== 1'b0) begin n_fail++; $display("FAIL right_clr%0d got fc=%b mo=%b want 1 0", i, bus.field_clr, bus.match_over); end
        tick();
        n_checks++; if (bus.play_en !== 1'b1) begin n_fail++; $display("FAIL right_replay%0d got pe=%b want 1", i, bus.play_en); end
      end else begin
        n_checks++; if (bus.match_over !== 1'b1 || bus.winner !== 2'b01) begin n_fail++; $display("FAIL match_over got mo=%b win=%b want 1 01", bus.match_over, bus.winner); end
        n_checks++; if (bus.r_score !== 3'd3 || bus.r_hex !== 7'b0110000 || bus.l_score !== 3'd1) begin
          n_fail++; $display("FAIL final_score got r=%0d hex=%b l=%0d want 3 0110000 1", bus.r_score, bus.r_hex, bus.l_score);
        end
        n_checks++; if (bus.field_clr !== 1'b0 || bus.play_en !== 1'b0) begin n_fail++; $display("FAIL over_outputs got fc=%b pe=%b want 0 0", bus.field_clr, bus.play_en); end
      end
    end
    bus.r_win = 1'b1;
    repeat (2) tick();
    bus.r_win = 1'b0;
    n_checks++; if (bus.r_score !== 3'd3 || bus.match_over !== 1'b1) begin n_fail++; $display("FAIL score_sat got r=%0d mo=%b want 3 1", bus.r_score, bus.match_over); end
  endtask

  task automatic test_restart();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.l_score !== 3'd0 || bus.r_score !== 3'd0 || bus.winner !== 2'b00 || bus.match_over !== 1'b0) begin
      n_fail++; $display("FAIL restart_clear got l=%0d r=%0d win=%b mo=%b want 0 0 00 0", bus.l_score, bus.r_score, bus.winner, bus.match_over);
    end
    n_checks++; if (bus.field_clr !== 1'b1 || bus.l_hex !== 7'b1000000 || bus.r_hex !== 7'b1000000) begin
      n_fail++; $display("FAIL restart_clr got fc=%b hex=%b/%b want 1 1000000", bus.field_clr, bus.l_hex, bus.r_hex);
    end
    tick();
    n_checks++; if (bus.play_en !== 1'b1) begin n_fail++; $display("FAIL restart_play got pe=%b want 1", bus.play_en); end
  endtask

  task automatic test_async_reset();
    bus.l_win = 1'b1;
    tick();
    bus.l_win = 1'b0;
    tick();
    // Mid-hold, between edges
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.l_score !== 3'd0 || bus.l_hex !== 7'b1000000 || bus.play_en !== 1'b0 || bus.field_clr !== 1'b0 || bus.match_over !== 1'b0 || bus.winner !== 2'b00) begin
      n_fail++; $display("FAIL async_reset got l=%0d hex=%b pe=%b fc=%b mo=%b win=%b want 0 1000000 0 0 0 00",
                         bus.l_score, bus.l_hex, bus.play_en, bus.field_clr, bus.match_over, bus.winner);
    end
    #2 reset = 1'b1;
    repeat (6) begin
      tick();
      n_checks++; if (bus.field_clr !== 1'b0 || bus.play_en !== 1'b0) begin n_fail++; $display("FAIL post_reset got fc=%b pe=%b want 0 0", bus.field_clr, bus.play_en); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_seg[0] = 7'b1000000; exp_seg[1] = 7'b1111001; exp_seg[2] = 7'b0100100; exp_seg[3] = 7'b0110000;
    exp_seg[4] = 7'b0011001; exp_seg[5] = 7'b0010010; exp_seg[6] = 7'b0000010; exp_seg[7] = 7'b1111000;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.l_win = 1'b0;
    bus.r_win = 1'b0;
    #12;
    test_reset();
    reset = 1'b1;
    test_idle_ignore();
    test_start();
    test_left_win();
    test_tie();
    test_right_match();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
